// File: rtl/boot_loader_pkg.sv
// Shared types and sizing helpers for the program loader / run controller.
package boot_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_LOAD,
      ST_DRAIN,
      ST_RUN,
      ST_DONE
   } state_e;

   // Width of bytes_loaded: must hold the value MAX_BYTES itself.
   function automatic int cnt_width(input int max_bytes);
      return $clog2(max_bytes + 1);
   endfunction

   // CLR_WORDS: number of words in the memory, 2^ADDR_W.
   function automatic int clr_words(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/boot_lane_ptr.sv
// Byte pointer for image loading: one-hot lane enable, word address and overflow flag.
module boot_lane_ptr
   import boot_loader_pkg::*;
#(
   parameter int LANES  = 4,
   parameter int ADDR_W = 20,
   parameter int CNT_W  = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              inc_i,
   output logic [CNT_W-1:0]  cnt_o,
   output logic [LANES-1:0]  lane_oh_o,
   output logic [ADDR_W-1:0] word_o,
   output logic              ovf_o
);

   localparam int LB = $clog2(LANES);
   localparam int WW = (CNT_W > ADDR_W) ? CNT_W : ADDR_W;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WW-1:0]    word_ext;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Word index is computed wide so addresses past the memory top are detectable.
   assign word_ext  = WW'(cnt_q) >> LB;
   assign word_o    = word_ext[ADDR_W-1:0];
   assign ovf_o     = word_ext > WW'(clr_words(ADDR_W) - 1);
   assign lane_oh_o = LANES'(1) << (cnt_q & CNT_W'(LANES - 1));
   assign cnt_o     = cnt_q;

endmodule

// File: rtl/boot_loader.sv
// Program loader and run controller: clears memory, streams the image in bytewise,
// then enables the core for a fixed cycle budget and flags completion.
module boot_loader
   import boot_loader_pkg::*;
#(
   parameter int LANES      = 4,
   parameter int ADDR_W     = 20,
   parameter int MAX_BYTES  = 384,
   parameter int RUN_CYCLES = 8000,
   parameter bit CLEAR_EN   = 1'b1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic                               byte_valid,
   input  logic [7:0]                         byte_data,
   input  logic                               byte_last,
   output logic                               byte_ready,
   output logic [LANES-1:0]                   mem_we,
   output logic [ADDR_W-1:0]                  mem_addr,
   output logic [7:0]                         mem_wdata,
   output logic                               core_en,
   output logic                               done,
   output logic [cnt_width(MAX_BYTES)-1:0]    bytes_loaded
);

   localparam int CNT_W     = cnt_width(MAX_BYTES);
   localparam int RUN_W     = $clog2(RUN_CYCLES + 1);
   localparam int CLR_WORDS = clr_words(ADDR_W);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
   logic [LANES-1:0]  we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;

   logic              hs;
   logic              ptr_clr;
   logic [CNT_W-1:0]  ptr_cnt;
   logic [LANES-1:0]  lane_oh;
   logic [ADDR_W-1:0] word;
   logic              ovf;

   assign hs = (state_q == ST_LOAD) && byte_valid;

   boot_lane_ptr #(
      .LANES  (LANES),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) u_ptr (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (ptr_clr),
      .inc_i     (hs),
      .cnt_o     (ptr_cnt),
      .lane_oh_o (lane_oh),
      .word_o    (word),
      .ovf_o     (ovf)
   );

   // Memory-port values are decided here and registered, so each write trails its cause by one cycle.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      run_cnt_d = run_cnt_q;
      we_d      = '0;
      addr_d    = '0;
      wdata_d   = '0;
      ptr_clr   = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               ptr_clr = 1'b1;
               if (CLEAR_EN) begin
                  state_d   = ST_CLEAR;
                  clr_cnt_d = '0;
                  we_d      = '1;
               end else begin
                  state_d = ST_LOAD;
               end
            end
         end
         ST_CLEAR: begin
            if (clr_cnt_q == ADDR_W'(CLR_WORDS - 1)) begin
               state_d = ST_LOAD;
               ptr_clr = 1'b1;
            end else begin
               clr_cnt_d = clr_cnt_q + ADDR_W'(1);
               we_d      = '1;
               addr_d    = clr_cnt_q + ADDR_W'(1);
            end
         end
         ST_LOAD: begin
            if (hs) begin
               we_d    = ovf ? '0 : lane_oh;
               addr_d  = word;
               wdata_d = byte_data;
               if (byte_last || (ptr_cnt == CNT_W'(MAX_BYTES - 1))) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            state_d   = ST_RUN;
            run_cnt_d = '0;
         end
         ST_RUN: begin
            if (run_cnt_q == RUN_W'(RUN_CYCLES - 1)) begin
               state_d = ST_DONE;
            end else begin
               run_cnt_d = run_cnt_q + RUN_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         clr_cnt_q <= '0;
         run_cnt_q <= '0;
         we_q      <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         run_cnt_q <= run_cnt_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
      end
   end

   assign byte_ready   = (state_q == ST_LOAD);
   assign core_en      = (state_q == ST_RUN);
   assign done         = (state_q == ST_DONE);
   assign mem_we       = we_q;
   assign mem_addr     = addr_q;
   assign mem_wdata    = wdata_q;
   assign bytes_loaded = ptr_cnt;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: scenario table plus random loads, checked against an image-placement model.
module tb_boot_loader;

   localparam int L  = 4;
   localparam int AW = 4;
   localparam int MB = 16;
   localparam int RC = 10;

   typedef struct {
      int n_off;
      int last_at;
      int mode;
      bit fixed;
      int exp_acc;
   } vec_t;

   logic       clk, rst, start, byte_valid, byte_last;
   logic [7:0] byte_data;
   logic       rdy1, rdy0, ce1, ce0, dn1, dn0;
   logic [3:0] we1, we0, addr1, addr0;
   logic [7:0] wd1, wd0;
   logic [4:0] bl1, bl0;

   logic       sel0, scrub;
   logic       s_rdy, s_ce, s_dn;
   logic [3:0] s_we, s_addr;
   logic [7:0] s_wd;
   logic [4:0] s_bl;

   logic [31:0] ram1 [16];
   logic [31:0] ram0 [16];
   logic [7:0]  fix_img [6];
   vec_t        tbl [6];

   int checks = 0;
   int fails  = 0;

   boot_loader #(.LANES(L), .ADDR_W(AW), .MAX_BYTES(MB), .RUN_CYCLES(RC), .CLEAR_EN(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_last(byte_last), .byte_ready(rdy1), .mem_we(we1), .mem_addr(addr1),
      .mem_wdata(wd1), .core_en(ce1), .done(dn1), .bytes_loaded(bl1)
   );

   boot_loader #(.LANES(L), .ADDR_W(AW), .MAX_BYTES(MB), .RUN_CYCLES(RC), .CLEAR_EN(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_last(byte_last), .byte_ready(rdy0), .mem_we(we0), .mem_addr(addr0),
      .mem_wdata(wd0), .core_en(ce0), .done(dn0), .bytes_loaded(bl0)
   );

   assign s_rdy  = sel0 ? rdy0  : rdy1;
   assign s_ce   = sel0 ? ce0   : ce1;
   assign s_dn   = sel0 ? dn0   : dn1;
   assign s_we   = sel0 ? we0   : we1;
   assign s_addr = sel0 ? addr0 : addr1;
   assign s_wd   = sel0 ? wd0   : wd1;
   assign s_bl   = sel0 ? bl0   : bl1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte-lane memories fed by the DUT write ports.
   always @(posedge clk) begin
      if (scrub) begin
         for (int w = 0; w < 16; w++) begin
            ram1[w] <= 32'hA5C3_5A3C ^ w;
            ram0[w] <= 32'h5AC3_A53C ^ w;
         end
      end else begin
         for (int l = 0; l < L; l++) begin
            if (we1[l]) ram1[addr1][8*l +: 8] <= wd1;
            if (we0[l]) ram0[addr0][8*l +: 8] <= wd0;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One full start -> load -> drain -> run -> done sequence on the selected DUT.
   task automatic run_case(input int n_off, input int last_at, input int mode,
                           input bit fixed, input int exp_acc, input bit poke);
      logic [7:0]  img[$];
      logic [31:0] exp_mem [16];
      int  i, acc, p, c;
      bit  prev_hs, ended;
      img.delete();
      for (int k = 0; k < n_off; k++) img.push_back(fixed ? fix_img[k] : 8'($urandom));
      for (int w = 0; w < 16; w++) exp_mem[w] = sel0 ? ram0[w] : 32'h0;

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_clears", 64'({s_dn, s_bl}), 64'(0));
      if (!sel0) begin
         for (int k = 0; k < 16; k++) begin
            chk("clear_wr", 64'({s_rdy, s_we, s_addr, s_wd}), 64'({1'b0, 4'hF, 4'(k), 8'h00}));
            @(negedge clk);
         end
      end
      chk("load_entry", 64'({s_rdy, s_we}), 64'({1'b1, 4'h0}));

      i = 0; acc = 0; p = 0; c = 0; prev_hs = 1'b0; ended = 1'b0;
      while (!ended && c < 400) begin
         if (prev_hs)
            chk("load_wr", 64'({s_we, s_addr, s_wd}), 64'({4'(1 << (p % 4)), 4'(p / 4), img[p]}));
         else
            chk("no_wr", 64'(s_we), 64'(0));
         chk("ready_load", 64'(s_rdy), 64'(1));
         byte_valid = (i < n_off) && (mode == 0 || (mode == 1 && c % 2 == 0) ||
                                      (mode == 2 && $urandom_range(0, 1) == 1));
         byte_data  = (i < n_off) ? img[i] : 8'h00;
         byte_last  = (i == last_at);
         prev_hs    = byte_valid;
         if (byte_valid) begin
            p = i; i++; acc++;
            if (byte_last || acc == MB) ended = 1'b1;
         end
         @(negedge clk);
         c++;
      end
      if (!ended) begin
         chk("load_timeout", 64'(acc), 64'(exp_acc));
         byte_valid = 1'b0;
         return;
      end

      chk("drain_wr", 64'({s_we, s_addr, s_wd}), 64'({4'(1 << (p % 4)), 4'(p / 4), img[p]}));
      chk("drain_ctl", 64'({s_rdy, s_ce, s_dn}), 64'(0));
      byte_valid = (i < n_off);
      byte_data  = (i < n_off) ? img[i] : 8'h00;
      byte_last  = 1'b0;
      for (int k = 0; k < RC; k++) begin
         @(negedge clk);
         start = poke && (k == 3);
         chk("run", 64'({s_ce, s_dn, s_rdy, s_we}), 64'({1'b1, 1'b0, 1'b0, 4'h0}));
      end
      @(negedge clk);
      start = 1'b0; byte_valid = 1'b0;
      chk("done", 64'({s_ce, s_dn, s_rdy}), 64'({1'b0, 1'b1, 1'b0}));
      chk("bytes_loaded", 64'(s_bl), 64'(exp_acc));
      for (int j = 0; j < exp_acc; j++) exp_mem[j / 4][8 * (j % 4) +: 8] = img[j];
      for (int w = 0; w < 16; w++)
         chk("mem_word", 64'(sel0 ? ram0[w] : ram1[w]), 64'(exp_mem[w]));
      @(negedge clk);
      chk("done_hold", 64'({s_ce, s_dn, s_bl}), 64'({1'b0, 1'b1, 5'(exp_acc)}));
   endtask

   initial begin
      int n, la, ex;
      fix_img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
      tbl[0] = '{n_off: 6,  last_at: 5,  mode: 0, fixed: 1'b1, exp_acc: 6};
      tbl[1] = '{n_off: 20, last_at: -1, mode: 0, fixed: 1'b0, exp_acc: 16};
      tbl[2] = '{n_off: 16, last_at: 15, mode: 0, fixed: 1'b0, exp_acc: 16};
      tbl[3] = '{n_off: 8,  last_at: 7,  mode: 1, fixed: 1'b0, exp_acc: 8};
      tbl[4] = '{n_off: 3,  last_at: 2,  mode: 2, fixed: 1'b0, exp_acc: 3};
      tbl[5] = '{n_off: 1,  last_at: 0,  mode: 0, fixed: 1'b0, exp_acc: 1};

      rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; byte_last = 1'b0;
      scrub = 1'b1; sel0 = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset1", 64'({rdy1, we1, addr1, wd1, ce1, dn1, bl1}), 64'(0));
      chk("reset0", 64'({rdy0, we0, addr0, wd0, ce0, dn0, bl0}), 64'(0));
      rst = 1'b0; scrub = 1'b0;
      byte_valid = 1'b1;
      @(negedge clk);
      byte_valid = 1'b0;
      chk("idle_quiet", 64'({rdy1, we1, ce1, dn1, bl1}), 64'(0));

      for (int r = 0; r < 6; r++) begin
         run_case(tbl[r].n_off, tbl[r].last_at, tbl[r].mode, tbl[r].fixed, tbl[r].exp_acc, 1'b0);
         if (r == 0) begin
            chk("word0", 64'(ram1[0]), 64'(32'h0000_0013));
            chk("word1", 64'(ram1[1]), 64'(32'h0000_0093));
         end
      end

      for (int r = 0; r < 6; r++) begin
         n  = $urandom_range(1, 20);
         la = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
         if (la < 0 && n < MB) n = MB + $urandom_range(0, 4);
         ex = n;
         if (la >= 0 && la + 1 < ex) ex = la + 1;
         if (ex > MB) ex = MB;
         run_case(n, la, $urandom_range(0, 2), 1'b0, ex, 1'b0);
      end

      // Reset in the middle of a load, with a handshake offered in the reset cycle.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (16) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         byte_valid = 1'b1; byte_data = 8'($urandom); byte_last = 1'b0;
         @(negedge clk);
      end
      chk("pre_rst_count", 64'(bl1), 64'(5));
      rst = 1'b1; byte_data = 8'hEE;
      @(negedge clk);
      rst = 1'b0; byte_valid = 1'b0;
      chk("rst_midload", 64'({rdy1, we1, addr1, wd1, ce1, dn1, bl1}), 64'(0));
      @(negedge clk);
      chk("rst_idle_hold", 64'({rdy1, we1, addr1, wd1, ce1, dn1, bl1}), 64'(0));
      scrub = 1'b1;
      @(negedge clk);
      scrub = 1'b0;
      run_case(5, 4, 0, 1'b0, 5, 1'b0);

      // Loader without clear: start ignored in RUN, restart from DONE skips clearing.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sel0 = 1'b1;
      run_case(6, 5, 0, 1'b0, 6, 1'b1);
      run_case(7, 6, 1, 1'b0, 7, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/boot_loader.md
# boot_loader

Synthesizable program loader and run controller for the multi-cycle RISC-V core. It zero-clears the byte-lane instruction/data memory and streams a program image into it one byte at a time, mapping byte i to lane i%LANES of word i/LANES. It then holds the core enabled for a fixed cycle budget and reports completion. It replaces bench-side memory preloading, and the same bring-up sequence runs in simulation and on hardware.

## Interface
- LANES, 4: byte lanes per memory word (power of 2, 1..8)
- ADDR_W, 20: word-address width; memory depth is 2^ADDR_W words
- MAX_BYTES, 384: image byte limit; load ends when this many bytes are accepted
- RUN_CYCLES, 8000: number of cycles core_en stays high (≥1)
- CLEAR_EN, 1: 1 = zero all memory before load; 0 = skip the CLEAR state

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a load/run sequence; sampled only in IDLE or DONE
- byte_valid  in  1  image byte available
- byte_data  in  8  image byte
- byte_last  in  1  marks the final image byte; qualified by byte_valid
- byte_ready  out  1  loader accepts a byte this cycle
- mem_we  out  LANES  per-lane write enable (one-hot in LOAD, all-ones in CLEAR)
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  8  byte written to each enabled lane
- core_en  out  1  core clock-enable / run permission
- done  out  1  run budget exhausted; held until start or rst
- bytes_loaded  out  clog2(MAX_BYTES+1)  count of accepted bytes

## Operation
- States: IDLE, CLEAR, LOAD, DRAIN, RUN, DONE.
- IDLE: all outputs 0. On start, go to CLEAR if CLEAR_EN=1, otherwise go to LOAD.
- CLEAR: mem_we all-ones, mem_wdata=0, and mem_addr counts from 0 to 2^ADDR_W−1, one word per cycle. After the last word, go to LOAD. byte_ready=0.
- LOAD: byte_ready=1. A handshake is byte_valid&byte_ready. For each handshake, a byte pointer p (reset to 0 on entering LOAD) writes lane p%LANES at word p/LANES, then p increments.
- Load end: the load ends on the handshake carrying byte_last, or on the handshake that brings bytes_loaded to MAX_BYTES, whichever comes first. byte_ready drops in the following cycle.
- Partial final word: unwritten lanes are left untouched (0 after CLEAR).
- Word-address overflow: if p/LANES would exceed 2^ADDR_W−1, the byte is accepted but the write is suppressed (mem_we=0).
- DRAIN: one cycle in which the last write completes. Then go to RUN.
- RUN: core_en=1 for exactly RUN_CYCLES cycles, counted by a run counter. Then go to DONE.
- DONE: core_en=0 and done=1. bytes_loaded holds its value. start goes to CLEAR (or LOAD when CLEAR_EN=0) and clears done and bytes_loaded.
- start outside IDLE/DONE is ignored. byte_valid outside LOAD is ignored (no handshake).
- rst at any time: state=IDLE, all counters cleared, all outputs 0 in the next cycle. An in-flight write is dropped.

## Timing
- mem_we/mem_addr/mem_wdata are registered. A handshake in cycle t produces its write in cycle t+1.
- Back-to-back handshakes sustain one byte per cycle.
- start in cycle t → first CLEAR write in t+1. CLEAR takes 2^ADDR_W cycles. byte_ready rises in the first LOAD cycle.
- Last handshake at t → write at t+1 (DRAIN) → core_en=1 from t+2 through t+1+RUN_CYCLES → done=1 at t+2+RUN_CYCLES.
- byte_last and MAX_BYTES reached on the same handshake: a single load end, with no extra cycle.
- Reset value of every output is 0.

## Structure
- Package boot_loader_pkg holds:
  - the state enum
  - the function for the bytes_loaded width
  - the constant CLR_WORDS = 2^ADDR_W
- Sub-module boot_lane_ptr: byte-pointer counter producing the one-hot lane enable and word address, plus the overflow flag. Clear-on-enter input and increment input.
- The FSM, the CLEAR address counter and the RUN counter live in boot_loader.

## Test plan
Parameters for all cases: LANES=4, ADDR_W=4, MAX_BYTES=16, RUN_CYCLES=10.
- Stream 0x13,0x00,0x00,0x00,0x93,0x00 with last on the 6th byte:
  - CLEAR writes words 0..15 with 0
  - word0 = 0x00000013
  - word1 lanes0/1 = 0x93/0x00, lanes 2/3 stay 0
  - bytes_loaded = 6
- After the last byte: DRAIN for one cycle, then core_en high for exactly 10 cycles, then done=1 and core_en=0.
- byte_valid toggled every other cycle: only handshake cycles write, and each write lands exactly one cycle after its handshake.
- 20 bytes offered without last:
  - 16 accepted, then byte_ready=0
  - word3 lane3 = byte 16
  - bytes 17..20 are never accepted
- rst asserted mid-LOAD after 5 bytes: the next cycle shows state IDLE with all outputs 0. A fresh start with CLEAR_EN=1 re-zeroes memory.
- CLEAR_EN=0, start during RUN: start ignored. After DONE, a second start loads directly (no CLEAR writes) and clears done.
